// File: rtl/id_stage_pipe_pkg.sv
// ============================================================================
// Module   : id_stage_pipe_pkg
// Brief    : Opcode constants, immediate-extension kind and field extractors
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package id_stage_pipe_pkg;

  localparam logic [5:0] c_op_load = 6'h23;
  localparam logic [5:0] c_op_andi = 6'h0C;
  localparam logic [5:0] c_op_ori  = 6'h0D;
  localparam logic [5:0] c_op_xori = 6'h0E;

  typedef enum logic [0:0] {
    IMM_SEXT = 1'b0,
    IMM_ZEXT = 1'b1
  } imm_ext_e;

  function automatic logic [5:0] f_opcode(input logic [31:0] instr);
    return instr[31:26];
  endfunction

  function automatic logic [4:0] f_rs(input logic [31:0] instr);
    return instr[25:21];
  endfunction

  function automatic logic [4:0] f_rt(input logic [31:0] instr);
    return instr[20:16];
  endfunction

  function automatic logic [4:0] f_rd(input logic [31:0] instr);
    return instr[15:11];
  endfunction

  function automatic logic [4:0] f_shamt(input logic [31:0] instr);
    return instr[10:6];
  endfunction

  function automatic logic [5:0] f_funct(input logic [31:0] instr);
    return instr[5:0];
  endfunction

  function automatic logic [15:0] f_imm(input logic [31:0] instr);
    return instr[15:0];
  endfunction

  function automatic logic f_is_logic_imm(input logic [5:0] op);
    return (op == c_op_andi) || (op == c_op_ori) || (op == c_op_xori);
  endfunction

endpackage

`default_nettype wire

// File: rtl/id_stage_pipe_if.sv
// ============================================================================
// Module   : id_stage_pipe_if
// Brief    : IF/ID, WB and ID/EX signal bundle of the decode stage
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface id_stage_pipe_if #(
  parameter int WORD_W = 32,
  parameter int ADDR_W = 5
);

  logic              if_valid;
  logic [WORD_W-1:0] ir;
  logic              id_ready;
  logic              flush;
  logic              wb_we;
  logic [ADDR_W-1:0] wb_addr;
  logic [WORD_W-1:0] wb_data;
  logic              ex_ready;
  logic              ex_valid;
  logic [WORD_W-1:0] ex_rdata1;
  logic [WORD_W-1:0] ex_rdata2;
  logic [WORD_W-1:0] ex_imm;
  logic [ADDR_W-1:0] ex_rs;
  logic [ADDR_W-1:0] ex_rt;
  logic [ADDR_W-1:0] ex_rd;
  logic [5:0]        ex_opcode;
  logic [4:0]        ex_shamt;
  logic [5:0]        ex_funct;

  modport master (
    output if_valid, ir, flush, wb_we, wb_addr, wb_data, ex_ready,
    input  id_ready, ex_valid, ex_rdata1, ex_rdata2, ex_imm,
           ex_rs, ex_rt, ex_rd, ex_opcode, ex_shamt, ex_funct
  );

  modport slave (
    input  if_valid, ir, flush, wb_we, wb_addr, wb_data, ex_ready,
    output id_ready, ex_valid, ex_rdata1, ex_rdata2, ex_imm,
           ex_rs, ex_rt, ex_rd, ex_opcode, ex_shamt, ex_funct
  );

endinterface

`default_nettype wire

// File: rtl/id_stage_pipe_regfile_2r1w.sv
// ============================================================================
// Module   : regfile_2r1w
// Brief    : Two-read / one-write register file, write-first read bypass
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_2r1w #(
  parameter int WORD_W    = 32,
  parameter int REG_DEPTH = 32,
  parameter bit ZERO_REG  = 1'b1,
  localparam int ADDR_W   = $clog2(REG_DEPTH)
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              we,
  input  wire logic [ADDR_W-1:0] waddr,
  input  wire logic [WORD_W-1:0] wdata,
  input  wire logic [ADDR_W-1:0] raddr1,
  input  wire logic [ADDR_W-1:0] raddr2,
  output logic      [WORD_W-1:0] rdata1,
  output logic      [WORD_W-1:0] rdata2
);

  logic [WORD_W-1:0] r_mem [REG_DEPTH];
  logic              w_wr_legal;
  logic              w_rd1_legal;
  logic              w_rd2_legal;
  logic              w_wr_en;

  // A power-of-two depth makes every address encodable and therefore legal.
  generate
    if (REG_DEPTH == (1 << ADDR_W)) begin : g_full_decode
      assign w_wr_legal  = 1'b1;
      assign w_rd1_legal = 1'b1;
      assign w_rd2_legal = 1'b1;
    end else begin : g_partial_decode
      assign w_wr_legal  = int'(waddr)  < REG_DEPTH;
      assign w_rd1_legal = int'(raddr1) < REG_DEPTH;
      assign w_rd2_legal = int'(raddr2) < REG_DEPTH;
    end
  endgenerate

  assign w_wr_en = we && w_wr_legal && !(ZERO_REG && (waddr == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_mem[waddr] <= wdata;
    end
  end

  // Zero-register masking takes precedence over the bypass path.
  assign rdata1 = (!w_rd1_legal || (ZERO_REG && (raddr1 == '0))) ? '0 :
                  (we && (waddr == raddr1))                      ? wdata :
                                                                   r_mem[raddr1];

  assign rdata2 = (!w_rd2_legal || (ZERO_REG && (raddr2 == '0))) ? '0 :
                  (we && (waddr == raddr2))                      ? wdata :
                                                                   r_mem[raddr2];

endmodule

`default_nettype wire

// File: rtl/id_stage_pipe.sv
// ============================================================================
// Module   : id_stage_pipe
// Brief    : Instruction decode stage with regfile, hazard stall, ID/EX reg
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_stage_pipe
  import id_stage_pipe_pkg::*;
#(
  parameter int         WORD_W     = 32,
  parameter int         REG_DEPTH  = 32,
  parameter bit         ZERO_REG   = 1'b1,
  parameter bit         ZEXT_LOGIC = 1'b1,
  parameter logic [5:0] LOAD_OP    = c_op_load,
  localparam int        ADDR_W     = $clog2(REG_DEPTH)
) (
  input wire logic         clk,
  input wire logic         rst_n,
  id_stage_pipe_if.slave   bus
);

  logic [31:0]       w_instr;
  logic [5:0]        w_opcode;
  logic [ADDR_W-1:0] w_rs;
  logic [ADDR_W-1:0] w_rt;
  logic [ADDR_W-1:0] w_rd;
  logic [WORD_W-1:0] w_rdata1;
  logic [WORD_W-1:0] w_rdata2;
  logic [WORD_W-1:0] w_imm;
  imm_ext_e          w_ext;
  logic              w_haz;
  logic              w_id_ready;
  logic              w_accept;

  logic              r_ex_valid;
  logic [WORD_W-1:0] r_ex_rdata1;
  logic [WORD_W-1:0] r_ex_rdata2;
  logic [WORD_W-1:0] r_ex_imm;
  logic [ADDR_W-1:0] r_ex_rs;
  logic [ADDR_W-1:0] r_ex_rt;
  logic [ADDR_W-1:0] r_ex_rd;
  logic [5:0]        r_ex_opcode;
  logic [4:0]        r_ex_shamt;
  logic [5:0]        r_ex_funct;

  assign w_instr  = bus.ir[31:0];
  assign w_opcode = f_opcode(w_instr);
  assign w_rs     = ADDR_W'(f_rs(w_instr));
  assign w_rt     = ADDR_W'(f_rt(w_instr));
  assign w_rd     = ADDR_W'(f_rd(w_instr));

  regfile_2r1w #(
    .WORD_W    (WORD_W),
    .REG_DEPTH (REG_DEPTH),
    .ZERO_REG  (ZERO_REG)
  ) u_regfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (bus.wb_we),
    .waddr  (bus.wb_addr),
    .wdata  (bus.wb_data),
    .raddr1 (w_rs),
    .raddr2 (w_rt),
    .rdata1 (w_rdata1),
    .rdata2 (w_rdata2)
  );

  assign w_ext = (ZEXT_LOGIC && f_is_logic_imm(w_opcode)) ? IMM_ZEXT : IMM_SEXT;
  assign w_imm = (w_ext == IMM_ZEXT) ? {{(WORD_W-16){1'b0}},       f_imm(w_instr)}
                                     : {{(WORD_W-16){w_instr[15]}}, f_imm(w_instr)};

  // Load result is not available until after EX; a dependent instruction waits one cycle.
  assign w_haz = r_ex_valid && (r_ex_opcode == LOAD_OP) && (r_ex_rt != '0) &&
                 ((r_ex_rt == w_rs) || (r_ex_rt == w_rt));

  assign w_id_ready = (!r_ex_valid || bus.ex_ready) && !w_haz && !bus.flush;
  assign w_accept   = bus.if_valid && w_id_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_valid  <= 1'b0;
      r_ex_rdata1 <= '0;
      r_ex_rdata2 <= '0;
      r_ex_imm    <= '0;
      r_ex_rs     <= '0;
      r_ex_rt     <= '0;
      r_ex_rd     <= '0;
      r_ex_opcode <= '0;
      r_ex_shamt  <= '0;
      r_ex_funct  <= '0;
    end else if (bus.flush) begin
      r_ex_valid <= 1'b0;
    end else if (!r_ex_valid || bus.ex_ready) begin
      r_ex_valid <= w_accept;
      if (w_accept) begin
        r_ex_rdata1 <= w_rdata1;
        r_ex_rdata2 <= w_rdata2;
        r_ex_imm    <= w_imm;
        r_ex_rs     <= w_rs;
        r_ex_rt     <= w_rt;
        r_ex_rd     <= w_rd;
        r_ex_opcode <= w_opcode;
        r_ex_shamt  <= f_shamt(w_instr);
        r_ex_funct  <= f_funct(w_instr);
      end
    end
  end

  assign bus.id_ready  = w_id_ready;
  assign bus.ex_valid  = r_ex_valid;
  assign bus.ex_rdata1 = r_ex_rdata1;
  assign bus.ex_rdata2 = r_ex_rdata2;
  assign bus.ex_imm    = r_ex_imm;
  assign bus.ex_rs     = r_ex_rs;
  assign bus.ex_rt     = r_ex_rt;
  assign bus.ex_rd     = r_ex_rd;
  assign bus.ex_opcode = r_ex_opcode;
  assign bus.ex_shamt  = r_ex_shamt;
  assign bus.ex_funct  = r_ex_funct;

endmodule

`default_nettype wire

// File: tb/tb_id_stage_pipe.sv
// ============================================================================
// Module   : tb_id_stage_pipe
// Brief    : Scoreboard bench for id_stage_pipe with directed instruction vectors
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_stage_pipe;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  id_stage_pipe_if #(.WORD_W(32), .ADDR_W(5)) bus ();

  id_stage_pipe #(
    .WORD_W     (32),
    .REG_DEPTH  (32),
    .ZERO_REG   (1'b1),
    .ZEXT_LOGIC (1'b1),
    .LOAD_OP    (6'h23)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] imm;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Present an instruction until the stage accepts it; the expected ID/EX image is queued on accept.
  task automatic issue(input logic [31:0] instr, input logic [31:0] r1,
                       input logic [31:0] r2, input logic [31:0] imm);
    bit ok = 1'b0;
    bus.if_valid = 1'b1;
    bus.ir       = instr;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (bus.id_ready) begin
        exp_q.push_back(exp_t'{instr, r1, r2, imm});
        ok = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    bus.if_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout ir=%h id_ready=0 required=1", instr);
    end
  endtask

  // Monitor: every consumed ID/EX word is checked against the head of the queue.
  initial begin
    exp_t          e;
    logic [127:0]  act;
    logic [127:0]  req;
    forever begin
      @(negedge clk);
      if (rst_n && bus.ex_valid && bus.ex_ready) begin
        checks++;
        act = {bus.ex_rdata1, bus.ex_rdata2, bus.ex_imm, bus.ex_opcode, bus.ex_rs,
               bus.ex_rt, bus.ex_rd, bus.ex_shamt, bus.ex_funct};
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ex_word actual=%h required=none", act);
        end else begin
          e   = exp_q.pop_front();
          req = {e.r1, e.r2, e.imm, e.instr[31:26], e.instr[25:21], e.instr[20:16],
                 e.instr[15:11], e.instr[10:6], e.instr[5:0]};
          if (act !== req) begin
            errors++;
            $display("FAIL ex_word ir=%h actual=%h required=%h", e.instr, act, req);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    bus.if_valid = 1'b0;
    bus.ir       = '0;
    bus.flush    = 1'b0;
    bus.wb_we    = 1'b0;
    bus.wb_addr  = '0;
    bus.wb_data  = '0;
    bus.ex_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_ex_valid", 64'(bus.ex_valid), 64'(0));
    chk("reset_rdata", {bus.ex_rdata1, bus.ex_rdata2}, 64'(0));
    chk("reset_fields", 64'({bus.ex_imm, bus.ex_opcode, bus.ex_rs, bus.ex_rt, bus.ex_rd}), 64'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Write r5 while reading it twice: bypass into both operands.
    bus.wb_we = 1'b1; bus.wb_addr = 5'd5; bus.wb_data = 32'hDEADBEEF;
    issue(32'h00A51820, 32'hDEADBEEF, 32'hDEADBEEF, 32'h00001820);
    bus.wb_we = 1'b0;
    issue(32'h00A03020, 32'hDEADBEEF, 32'h0, 32'h00003020);

    // Zero register: plain write, then write during the read cycle.
    bus.wb_we = 1'b1; bus.wb_addr = 5'd0; bus.wb_data = 32'h00001234;
    @(posedge clk);
    #1;
    issue(32'h00003820, 32'h0, 32'h0, 32'h00003820);
    bus.wb_we = 1'b0;

    // Immediate extension: addi sign-extends, ori zero-extends.
    issue(32'h20A88000, 32'hDEADBEEF, 32'h0, 32'hFFFF8000);
    issue(32'h34A98000, 32'hDEADBEEF, 32'h0, 32'h00008000);

    // Load-use: lw r2 followed by add r4,r2,r1.
    bus.wb_we = 1'b1; bus.wb_addr = 5'd1; bus.wb_data = 32'h00000011;
    @(posedge clk);
    #1;
    bus.wb_we = 1'b0;
    issue(32'h8CA20004, 32'hDEADBEEF, 32'h0, 32'h00000004);
    bus.if_valid = 1'b1;
    bus.ir       = 32'h00412020;
    @(negedge clk);
    chk("haz_id_ready", 64'(bus.id_ready), 64'(0));
    chk("haz_load_in_ex", 64'({bus.ex_valid, bus.ex_opcode}), 64'({1'b1, 6'h23}));
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("haz_bubble", 64'(bus.ex_valid), 64'(0));
    chk("haz_release", 64'(bus.id_ready), 64'(1));
    if (bus.id_ready) exp_q.push_back(exp_t'{32'h00412020, 32'h0, 32'h00000011, 32'h00002020});
    @(posedge clk);
    #1;
    bus.if_valid = 1'b0;

    // Backpressure for 3 cycles, then flush with a new instruction presented.
    issue(32'h00A03020, 32'hDEADBEEF, 32'h0, 32'h00003020);
    bus.ex_ready = 1'b0;
    bus.if_valid = 1'b1;
    bus.ir       = 32'h00E74020;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("hold_ex_valid", 64'(bus.ex_valid), 64'(1));
      chk("hold_payload", {bus.ex_rdata1, 27'd0, bus.ex_rd}, {32'hDEADBEEF, 27'd0, 5'd6});
      chk("hold_id_ready", 64'(bus.id_ready), 64'(0));
      @(posedge clk);
      #1;
    end
    bus.flush = 1'b1;
    @(negedge clk);
    chk("flush_id_ready", 64'(bus.id_ready), 64'(0));
    @(posedge clk);
    #1;
    bus.flush    = 1'b0;
    bus.if_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("flush_ex_valid", 64'(bus.ex_valid), 64'(0));
    bus.ex_ready = 1'b1;
    @(posedge clk);
    #1;

    // Reset asserted while ID/EX is held.
    issue(32'h00A03020, 32'hDEADBEEF, 32'h0, 32'h00003020);
    bus.ex_ready = 1'b0;
    @(negedge clk);
    chk("prereset_hold", 64'(bus.ex_valid), 64'(1));
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_ex_valid", 64'(bus.ex_valid), 64'(0));
    chk("midrst_rdata", {bus.ex_rdata1, bus.ex_rdata2}, 64'(0));
    chk("midrst_imm_rd", {bus.ex_imm, 27'd0, bus.ex_rd}, 64'(0));
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n        = 1'b1;
    bus.ex_ready = 1'b1;
    @(posedge clk);
    #1;
    issue(32'h00A51820, 32'h0, 32'h0, 32'h00001820);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 64'(exp_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
